// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl: pops scan-code bytes from a PS/2 receiver FIFO, folds
// E0/F0 prefixes into key events, tracks the currently held key and counts
// distinct presses. All outputs are registered.
module kbd_event_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [7:0]       ps2_data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic             is_press,
  output logic [CNT_W-1:0] press_count,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

  state_t     state_reg;
  logic       ext_pend_reg;
  logic       brk_pend_reg;
  logic [7:0] held_code_reg;
  logic       held_ext_reg;

  // The incoming byte names the held key when both code and prefix agree.
  logic held_match;
  assign held_match = is_press && (held_code_reg == ps2_data) && (held_ext_reg == ext_pend_reg);

  // Pop FSM, prefix parser, held-key tracker and error flag in one register stage.
  // The byte is decoded on the same edge that latches it, so the event strobe
  // lines up with the single POP cycle in which nextdata_n is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      nextdata_n    <= 1'b1;
      key_valid     <= 1'b0;
      key_code      <= 8'h00;
      key_ext       <= 1'b0;
      key_release   <= 1'b0;
      is_press      <= 1'b0;
      press_count   <= '0;
      err           <= 1'b0;
      ext_pend_reg  <= 1'b0;
      brk_pend_reg  <= 1'b0;
      held_code_reg <= 8'h00;
      held_ext_reg  <= 1'b0;
    end else begin
      nextdata_n <= 1'b1;
      key_valid  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ready) begin
            state_reg  <= POP;
            nextdata_n <= 1'b0;
            case (ps2_data)
              8'hE0: ext_pend_reg <= 1'b1;
              8'hF0: brk_pend_reg <= 1'b1;
              8'h00, 8'hFF: begin
                err          <= 1'b1;
                ext_pend_reg <= 1'b0;
                brk_pend_reg <= 1'b0;
              end
              default: begin
                key_valid    <= 1'b1;
                key_code     <= ps2_data;
                key_ext      <= ext_pend_reg;
                key_release  <= brk_pend_reg;
                ext_pend_reg <= 1'b0;
                brk_pend_reg <= 1'b0;
                // An overflow in this cycle wipes the tracker, so skip the update.
                if (!overflow) begin
                  if (brk_pend_reg) begin
                    if (held_match) is_press <= 1'b0;
                  end else if (!held_match) begin
                    is_press      <= 1'b1;
                    held_code_reg <= ps2_data;
                    held_ext_reg  <= ext_pend_reg;
                    press_count   <= press_count + CNT_W'(1);
                  end
                end
              end
            endcase
          end
        end
        POP:     state_reg <= SETTLE;
        SETTLE:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
      // Lost bytes make any partial sequence and the held state untrustworthy.
      if (overflow) begin
        err          <= 1'b1;
        ext_pend_reg <= 1'b0;
        brk_pend_reg <= 1'b0;
        is_press     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// tb_kbd_event_ctrl: table of byte sequences with hand-computed events and
// final state, plus directed sequences for reset, overflow and counter wrap.
module tb_kbd_event_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [7:0] ps2_data;
  logic       overflow;
  logic       nextdata_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       is_press;
  logic [7:0] press_count;
  logic       err;

  kbd_event_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ready(ready), .ps2_data(ps2_data), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_release(key_release), .is_press(is_press),
    .press_count(press_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] b;       // up to six bytes, first byte in the top octet
    int          n;
    int          n_ev;
    logic [9:0]  first;   // {code, ext, rel}
    logic [9:0]  last;
    logic        press;
    logic [7:0]  count;
    logic        err;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [7:0] fifo_q[$];
  logic [9:0] ev_q[$];
  int         pops;
  int         gap_bad;
  int         timed_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; ps2_data = 8'h00; overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Behaves as the receiver FIFO: ready while bytes remain, pop on nextdata_n low.
  task automatic feed(input int max_cyc);
    int cyc = 0;
    int last_pop = -1;
    int idle_cnt = 0;
    ev_q.delete();
    pops = 0; gap_bad = 0; timed_out = 0;
    while ((fifo_q.size() > 0 || idle_cnt < 3) && cyc < max_cyc) begin
      ready    = (fifo_q.size() > 0);
      ps2_data = ready ? fifo_q[0] : 8'h00;
      if (!ready) idle_cnt++;
      @(posedge clk); #1;
      if (key_valid) ev_q.push_back({key_code, key_ext, key_release});
      if (!nextdata_n) begin
        pops++;
        if (last_pop >= 0 && cyc - last_pop != 3) gap_bad++;
        last_pop = cyc;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      cyc++;
    end
    ready = 1'b0;
    if (cyc >= max_cyc) timed_out = 1;
  endtask

  function automatic vec_t mk(logic [47:0] b, int n, int n_ev, logic [9:0] first,
                              logic [9:0] last, logic press, logic [7:0] count, logic e);
    vec_t v;
    v.b = b; v.n = n; v.n_ev = n_ev; v.first = first; v.last = last;
    v.press = press; v.count = count; v.err = e;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    // {code, ext, rel} events written as 10-bit {8'hxx, ext, rel}
    vecs[0] = mk(48'h1CF01C000000, 3, 2, {8'h1C,2'b00}, {8'h1C,2'b01}, 0, 1, 0);
    vecs[1] = mk(48'hE075E0F07500, 5, 2, {8'h75,2'b10}, {8'h75,2'b11}, 0, 1, 0);
    vecs[2] = mk(48'h1C1C1CF01C00, 5, 4, {8'h1C,2'b00}, {8'h1C,2'b01}, 0, 1, 0);
    vecs[3] = mk(48'h1C32F01C0000, 4, 3, {8'h1C,2'b00}, {8'h1C,2'b01}, 1, 2, 0);
    vecs[4] = mk(48'h1C32F01CF032, 6, 4, {8'h1C,2'b00}, {8'h32,2'b01}, 0, 2, 0);
    vecs[5] = mk(48'h001C00000000, 2, 1, {8'h1C,2'b00}, {8'h1C,2'b00}, 1, 1, 1);
    vecs[6] = mk(48'hF0E01C000000, 3, 1, {8'h1C,2'b11}, {8'h1C,2'b11}, 0, 0, 0);
    vecs[7] = mk(48'hE0FF1C000000, 3, 1, {8'h1C,2'b00}, {8'h1C,2'b00}, 1, 1, 1);
    vecs[8] = mk(48'hF01C00000000, 2, 1, {8'h1C,2'b01}, {8'h1C,2'b01}, 0, 0, 0);
    vecs[9] = mk(48'hE01C1C000000, 3, 2, {8'h1C,2'b10}, {8'h1C,2'b00}, 1, 2, 0);

    do_reset();
    chk("rst_nextdata_n", nextdata_n, 1);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 8'h00);
    chk("rst_key_ext", key_ext, 0);
    chk("rst_key_release", key_release, 0);
    chk("rst_is_press", is_press, 0);

    for (int v = 0; v < 10; v++) begin
      do_reset();
      chk($sformatf("v%0d_rst_err", v), err, 0);
      chk($sformatf("v%0d_rst_count", v), press_count, 0);
      for (int i = 0; i < vecs[v].n; i++) begin
        logic [47:0] bb;
        bb = vecs[v].b << (8 * i);
        fifo_q.push_back(bb[47:40]);
      end
      feed(100);
      chk($sformatf("v%0d_timeout", v), timed_out, 0);
      chk($sformatf("v%0d_pops", v), pops, vecs[v].n);
      chk($sformatf("v%0d_pop_gap_bad", v), gap_bad, 0);
      chk($sformatf("v%0d_events", v), ev_q.size(), vecs[v].n_ev);
      if (ev_q.size() > 0) begin
        chk($sformatf("v%0d_first_event", v), ev_q[0], vecs[v].first);
        chk($sformatf("v%0d_last_event", v), ev_q[ev_q.size()-1], vecs[v].last);
      end
      chk($sformatf("v%0d_held_last", v), {key_code, key_ext, key_release}, vecs[v].last);
      chk($sformatf("v%0d_is_press", v), is_press, vecs[v].press);
      chk($sformatf("v%0d_press_count", v), press_count, vecs[v].count);
      chk($sformatf("v%0d_err", v), err, vecs[v].err);
    end

    // Reset after E0 discards the prefix; reset also beats a ready byte.
    do_reset();
    fifo_q.push_back(8'hE0);
    feed(50);
    rst = 1'b1; ready = 1'b1; ps2_data = 8'h1C;
    @(posedge clk); #1;
    chk("rst_dom_nextdata_n", nextdata_n, 1);
    chk("rst_dom_key_valid", key_valid, 0);
    rst = 1'b0; ready = 1'b0;
    fifo_q.push_back(8'h1C);
    feed(50);
    chk("rst_mid_events", ev_q.size(), 1);
    chk("rst_mid_event", {key_code, key_ext, key_release}, {8'h1C, 2'b00});

    // Overflow coinciding with a make byte: event still emitted, nothing held.
    do_reset();
    ready = 1'b1; ps2_data = 8'h1C; overflow = 1'b1;
    @(posedge clk); #1;
    chk("ovf_same_key_valid", key_valid, 1);
    chk("ovf_same_nextdata_n", nextdata_n, 0);
    chk("ovf_same_is_press", is_press, 0);
    chk("ovf_same_err", err, 1);
    ready = 1'b0; overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // 255 alternating makes, then E0, overflow, 1C: count wraps to zero.
    do_reset();
    for (int i = 0; i < 255; i++) fifo_q.push_back((i % 2 == 0) ? 8'h1C : 8'h32);
    feed(2000);
    chk("wrap_timeout", timed_out, 0);
    chk("wrap_preset_count", press_count, 8'hFF);
    chk("wrap_preset_press", is_press, 1);
    fifo_q.push_back(8'hE0);
    feed(50);
    overflow = 1'b1;
    @(posedge clk); #1;
    overflow = 1'b0;
    chk("wrap_ovf_err", err, 1);
    chk("wrap_ovf_is_press", is_press, 0);
    fifo_q.push_back(8'h1C);
    feed(50);
    chk("wrap_events", ev_q.size(), 1);
    chk("wrap_event", {key_code, key_ext, key_release}, {8'h1C, 2'b00});
    chk("wrap_count", press_count, 8'h00);
    chk("wrap_is_press", is_press, 1);
    chk("wrap_err_sticky", err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kbd_event_ctrl.md
KBD_EVENT_CTRL -- requirements
Module: kbd_event_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, press counter width.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ready  input  1  PS/2 receiver FIFO non-empty; ps2_data valid.
REQ-005 SHALL have port ps2_data  input  8  head byte of the receiver FIFO.
REQ-006 SHALL have port overflow  input  1  receiver FIFO overflow flag, level.
REQ-007 SHALL have port nextdata_n  output  1  active-low FIFO pop strobe.
REQ-008 SHALL have port key_valid  output  1  one-cycle key event strobe.
REQ-009 SHALL have port key_code  output  8  scan code of the last event.
REQ-010 SHALL have port key_ext  output  1  last event was E0-prefixed.
REQ-011 SHALL have port key_release  output  1  last event was a break (F0-prefixed).
REQ-012 SHALL have port is_press  output  1  a key is currently held.
REQ-013 SHALL have port press_count  output  CNT_W  count of distinct key presses.
REQ-014 SHALL have port err  output  1  sticky error: 0x00/0xFF byte or overflow seen.

Function
REQ-015 Pop FSM SHALL have states IDLE, POP, SETTLE; reset state IDLE.
REQ-016 IDLE: ready=1 -> latch ps2_data, go POP; else stay.
REQ-017 POP: nextdata_n=0 for exactly this one cycle, go SETTLE; nextdata_n=1 in all other states.
REQ-018 SETTLE: ignore ready for one cycle, go IDLE; max throughput one byte per 3 cycles.
REQ-019 Parser SHALL hold prefix flags ext_pend, brk_pend, both cleared on reset.
REQ-020 Latched 0xE0 -> ext_pend=1, no event.
REQ-021 Latched 0xF0 -> brk_pend=1, no event; E0 after F0 also sets ext_pend.
REQ-022 Latched 0x00 or 0xFF -> err=1, clear both prefix flags, no event.
REQ-023 Any other byte -> key_valid=1 in POP cycle; key_code=byte, key_ext=ext_pend, key_release=brk_pend; then clear both flags.
REQ-024 key_code/key_ext/key_release SHALL hold their value until the next event.
REQ-025 Held tracker SHALL store one held key {code, ext} plus held flag; is_press=held flag.
REQ-026 Make event, no key held -> store key, held=1, press_count+1.
REQ-027 Make event equal to held key (typematic repeat) -> no count change, key_valid still pulses.
REQ-028 Make event for a different key while held -> replace held key, press_count+1.
REQ-029 Break event matching held {code, ext} -> held=0; non-matching break -> held unchanged.
REQ-030 press_count SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-031 overflow=1 in any cycle -> err=1, clear prefix flags, held=0; pop FSM continues unaffected.
REQ-032 overflow and event in same cycle -> overflow clearing wins; event still emitted, held stays 0.
REQ-033 err SHALL clear only on reset.

Reset
REQ-034 rst=1 SHALL, on the clock edge, force IDLE, nextdata_n=1, key_valid=0, key_code=0x00, key_ext=0, key_release=0, is_press=0, press_count=0, err=0, prefix flags=0.
REQ-035 rst mid-sequence (e.g. after E0 or F0) SHALL discard the partial sequence; a pop in flight is not completed.
REQ-036 rst dominates all other inputs in the same cycle.

Verification
REQ-037 Bytes 1C, F0, 1C -> events (1C,ext0,rel0),(1C,ext0,rel1); press_count=1; is_press 1 then 0; one nextdata_n low pulse per byte.
REQ-038 Bytes E0, 75, E0, F0, 75 -> events (75,ext1,rel0),(75,ext1,rel1); press_count=1.
REQ-039 Bytes 1C, 1C, 1C, F0, 1C -> four key_valid pulses, press_count=1, is_press=0 at end.
REQ-040 Bytes 1C, 32, F0, 1C -> press_count=2, is_press=1 (held 32); then F0, 32 -> is_press=0.
REQ-041 ready held high continuously over 4 bytes -> nextdata_n low every third cycle, no byte lost or duplicated.
REQ-042 Byte E0, then overflow pulse, then 1C -> err=1, event (1C,ext0,rel0); press_count preset 0xFF -> wraps to 0x00.
